// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and data access.
// Optional round-robin arbitration is enabled by defining ARB_RR_EN.
module sram_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_addr_ok,
    output logic                inst_data_ok,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_addr_ok,
    output logic                data_data_ok,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_we,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata
);

    logic              grant_d;
    logic              grant_i;
    logic              prio_data;
    logic              rsp_vld;
    logic [RD_LAT-1:0] tag_vld_q;
    logic [RD_LAT-1:0] tag_own_q;

`ifdef ARB_RR_EN
    // Remembers the last winner so sustained conflicts alternate, data first after reset.
    logic last_d_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_d_q <= 1'b0;
        end else if (sram_en) begin
            last_d_q <= grant_d;
        end
    end

    assign prio_data = ~last_d_q;
`else
    assign prio_data = 1'b1;
`endif

    always_comb begin
        grant_d      = data_req & (prio_data | ~inst_req);
        grant_i      = inst_req & ~grant_d;
        inst_addr_ok = grant_i;
        data_addr_ok = grant_d;
        sram_en      = grant_d | grant_i;
        sram_we      = (grant_d & data_wr) ? data_wstrb : '0;
        sram_addr    = grant_d ? data_addr : inst_addr;
        sram_wdata   = data_wdata;
    end

    // Tag stage i holds the access granted i+1 cycles ago; the last stage lines up with rdata.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            tag_vld_q <= '0;
            tag_own_q <= '0;
        end else begin
            tag_vld_q[0] <= sram_en;
            tag_own_q[0] <= grant_d;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_own_q[i] <= tag_own_q[i-1];
            end
        end
    end

    always_comb begin
        rsp_vld      = resetn & tag_vld_q[RD_LAT-1];
        inst_data_ok = rsp_vld & ~tag_own_q[RD_LAT-1];
        data_data_ok = rsp_vld & tag_own_q[RD_LAT-1];
        inst_rdata   = sram_rdata;
        data_rdata   = sram_rdata;
    end

endmodule
